// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stage enables, bubble strobes,
// branch redirect, MDU busy tracking with watchdog, and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MDU_MAX_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_rs,
  input  logic             stall_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_flush,
  output logic             pc_redirect,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WD_W = (MDU_MAX_CYC > 2) ? $clog2(MDU_MAX_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_MAX_CYC - 1);

  typedef enum logic {
    RUN,
    MDU_BUSY
  } state_e;

  typedef struct packed {
    logic if_en;
    logic id_en;
    logic ex_en;
    logic mem_en;
    logic wb_en;
    logic id_flush;
    logic ex_flush;
    logic mem_flush;
    logic pc_redirect;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN  = '{if_en: 1'b1, id_en: 1'b1, ex_en: 1'b1, mem_en: 1'b1,
                                  wb_en: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_NONE = '0;

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  ctrl_t            ctrl;
  logic             mem_wait;

  assign mem_wait = dmem_req & ~dmem_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    ctrl      = CTRL_RUN;
    state_d   = state_q;
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;

    if (mem_wait) begin
      ctrl = CTRL_NONE;
    end else if (state_q == MDU_BUSY) begin
      if (mdu_done) begin
        state_d = RUN;
      end else begin
        ctrl.if_en     = 1'b0;
        ctrl.id_en     = 1'b0;
        ctrl.ex_en     = 1'b0;
        ctrl.mem_flush = 1'b1;
        if (wd_cnt_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = RUN;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
    end else begin
      // A taken branch discards the younger instruction in ID, so it wins over load-use.
      if (ex_branch_taken) begin
        ctrl.pc_redirect = 1'b1;
        ctrl.id_flush    = 1'b1;
        ctrl.ex_flush    = 1'b1;
      end else if (stall_rs | stall_rt) begin
        ctrl.if_en    = 1'b0;
        ctrl.id_en    = 1'b0;
        ctrl.ex_flush = 1'b1;
      end
      if (ex_mdu_start) begin
        state_d  = MDU_BUSY;
        wd_cnt_d = '0;
      end
    end

    stall_d = stall_q;
    if (!ctrl.if_en && stall_q != '1) stall_d = stall_q + CNT_W'(1);
    flush_d = flush_q;
    if (ctrl.pc_redirect && flush_q != '1) flush_d = flush_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  // Control strobes are forced low for the whole time reset is asserted.
  assign if_en        = rst_n & ctrl.if_en;
  assign id_en        = rst_n & ctrl.id_en;
  assign ex_en        = rst_n & ctrl.ex_en;
  assign mem_en       = rst_n & ctrl.mem_en;
  assign wb_en        = rst_n & ctrl.wb_en;
  assign id_flush     = rst_n & ctrl.id_flush;
  assign ex_flush     = rst_n & ctrl.ex_flush;
  assign mem_flush    = rst_n & ctrl.mem_flush;
  assign pc_redirect  = rst_n & ctrl.pc_redirect;
  assign mdu_timeout  = timeout_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle reference model plus directed
// scenarios with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 6;
  localparam int MAX_CYC = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_rs = 0, stall_rt = 0, ex_branch_taken = 0, ex_mdu_start = 0;
  logic mdu_done = 0, dmem_req = 0, dmem_ready = 0;
  logic if_en, id_en, ex_en, mem_en, wb_en, id_flush, ex_flush, mem_flush, pc_redirect;
  logic mdu_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MDU_MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .stall_rs(stall_rs), .stall_rt(stall_rt),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .if_en(if_en), .id_en(id_en),
    .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en), .id_flush(id_flush),
    .ex_flush(ex_flush), .mem_flush(mem_flush), .pc_redirect(pc_redirect),
    .mdu_timeout(mdu_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: "busy_age" is how many busy cycles the MDU op has lived through.
  bit m_busy;
  int m_age, m_stalls, m_flushes;
  bit m_timeout;

  always @(negedge rst_n) begin
    m_busy = 0; m_age = 0; m_stalls = 0; m_flushes = 0; m_timeout = 0;
  end

  function automatic logic [9:0] outs_vec();
    return {if_en, id_en, ex_en, mem_en, wb_en, id_flush, ex_flush, mem_flush,
            pc_redirect, mdu_timeout};
  endfunction

  always @(negedge clk) begin
    bit wait_mem, f_if, f_id, f_ex, f_mem, f_wb, f_idf, f_exf, f_memf, f_pcr;
    if (!rst_n) begin
      check("reset_outs", outs_vec(), 10'b0);
      check("reset_cnts", {stall_cycles, flush_count}, '0);
    end else begin
      wait_mem = dmem_req && !dmem_ready;
      {f_if, f_id, f_ex, f_mem, f_wb, f_idf, f_exf, f_memf, f_pcr} = 9'b11111_0000;
      if (wait_mem) begin
        {f_if, f_id, f_ex, f_mem, f_wb} = 5'b0;
      end else if (m_busy && !mdu_done) begin
        {f_if, f_id, f_ex} = 3'b0;
        f_memf = 1;
      end else if (!m_busy && ex_branch_taken) begin
        {f_pcr, f_idf, f_exf} = 3'b111;
      end else if (!m_busy && (stall_rs || stall_rt)) begin
        {f_if, f_id} = 2'b0;
        f_exf = 1;
      end
      check("model_outs", outs_vec(),
            {f_if, f_id, f_ex, f_mem, f_wb, f_idf, f_exf, f_memf, f_pcr, m_timeout});
      check("model_stall_cycles", 32'(stall_cycles), m_stalls);
      check("model_flush_count", 32'(flush_count), m_flushes);

      if (!f_if) m_stalls = (m_stalls == CNT_MAX) ? CNT_MAX : m_stalls + 1;
      if (f_pcr) m_flushes = (m_flushes == CNT_MAX) ? CNT_MAX : m_flushes + 1;
      if (!wait_mem) begin
        if (m_busy) begin
          m_age++;
          if (mdu_done) m_busy = 0;
          else if (m_age == MAX_CYC) begin m_busy = 0; m_timeout = 1; end
        end else if (ex_mdu_start) begin
          m_busy = 1;
          m_age = 0;
        end
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    #1;
    check("rst_if_en", 32'(if_en), 0);
    #11 rst_n = 1;
    tick();

    // T1: single-cycle load-use stall
    stall_rs = 1;
    #2 check("t1_ctrl", {if_en, id_en, ex_flush, ex_en}, 4'b0011);
    tick(); stall_rs = 0;
    check("t1_stall_cycles", 32'(stall_cycles), 1);

    // T2: branch overrides load-use
    ex_branch_taken = 1; stall_rt = 1;
    #2 check("t2_ctrl", {pc_redirect, id_flush, ex_flush, if_en, id_en}, 5'b11111);
    tick(); ex_branch_taken = 0; stall_rt = 0;
    check("t2_flush_count", 32'(flush_count), 1);
    check("t2_stall_cycles", 32'(stall_cycles), 1);

    // T3: MDU op completes 5 cycles after issue
    ex_mdu_start = 1;
    #2 check("t3_issue_if_en", 32'(if_en), 1);
    tick(); ex_mdu_start = 0;
    for (int i = 0; i < 4; i++) begin
      #2 check("t3_busy", {if_en, id_en, ex_en, mem_en, wb_en, mem_flush}, 6'b000111);
      tick();
    end
    mdu_done = 1;
    #2 check("t3_done", {if_en, mem_flush}, 2'b10);
    tick(); mdu_done = 0;
    check("t3_stall_cycles", 32'(stall_cycles), 5);

    // T4: watchdog abort after MAX_CYC busy cycles
    ex_mdu_start = 1;
    tick(); ex_mdu_start = 0;
    n = 0;
    #2;
    while (!if_en && n < 40) begin n++; tick(); #2; end
    check("t4_busy_len", n, MAX_CYC);
    check("t4_timeout", 32'(mdu_timeout), 1);
    tick();
    mdu_done = 1;
    #2 check("t4_done_ignored", {if_en, mem_flush, mdu_timeout}, 3'b101);
    tick(); mdu_done = 0;
    check("t4_sticky", 32'(mdu_timeout), 1);

    // T5: memory wait freezes the watchdog mid-busy
    ex_mdu_start = 1;
    tick(); ex_mdu_start = 0;
    tick(); tick();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2 check("t5_wait", {if_en, id_en, ex_en, mem_en, wb_en, mem_flush}, 6'b0);
      tick();
    end
    dmem_req = 0;
    n = 0;
    #2;
    while (!if_en && n < 40) begin n++; tick(); #2; end
    check("t5_remaining", n, MAX_CYC - 2);
    tick();
    check("t5_stall_cycles", 32'(stall_cycles), 5 + MAX_CYC + MAX_CYC + 3);

    // T6: asynchronous reset in the middle of a busy period
    ex_mdu_start = 1;
    tick(); ex_mdu_start = 0;
    tick();
    #1 rst_n = 0;
    #1 check("t6_async_outs", {if_en, mem_en, wb_en, mdu_timeout}, 4'b0);
    check("t6_async_cnt", 32'(stall_cycles), 0);
    #1 rst_n = 1;
    tick();
    #2 check("t6_run", {if_en, mem_flush, mdu_timeout}, 3'b100);
    tick();
    stall_rt = 1;
    for (int i = 0; i < CNT_MAX + 10; i++) tick();
    stall_rt = 0;
    check("t6_saturate", 32'(stall_cycles), CNT_MAX);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
